// File: rtl/evm_pkg.sv
// Shared types and sizing helpers for the vote-acknowledge path.
package evm_pkg;

   typedef enum logic [1:0] {
      ACK_IDLE = 2'd0,
      ACK_ON   = 2'd1,
      ACK_GAP  = 2'd2
   } ack_state_t;

   // Counter width for the larger of two cycle counts; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int pend_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Up-counter cleared (loaded with zero) on request, with a terminal-count flag against a runtime limit.
module hold_timer #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic [W-1:0] i_limit,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   // Count state; the owner clears at terminal count so the counter never wraps.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/vote_ack_stretcher.sv
// Stretches single-cycle vote pulses into HOLD_CYCLES-high bursts separated by GAP_CYCLES-low gaps.
// Define VOTE_ACK_QUEUE_EN to queue pulses arriving during a burst/gap and replay them in order.
module vote_ack_stretcher
   import evm_pkg::*;
#(
   parameter int HOLD_CYCLES = 50000000,
   parameter int GAP_CYCLES  = 25000000,
   parameter int MAX_PENDING = 7
) (
   input  logic                                clock,
   input  logic                                Reset,
   input  logic                                din,
   output logic                                dout,
   output logic                                busy,
   output logic [pend_width(MAX_PENDING)-1:0]  pending,
   output logic                                overflow
);

   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int PW = pend_width(MAX_PENDING);

   ack_state_t      r_state;
   ack_state_t      w_state_nxt;
   logic            r_dout;
   logic            r_busy;
   logic            r_ovf;
   logic            w_ovf_nxt;
   logic            w_tmr_clr;
   logic            w_tc;
   logic            w_accept;
   logic [CW-1:0]   w_limit;
`ifdef VOTE_ACK_QUEUE_EN
   logic [PW-1:0]   r_pend;
   logic [PW-1:0]   w_pend_nxt;
   logic            w_dec;
   logic            w_sat;
`endif

   hold_timer #(.W(CW)) u_timer (
      .i_clk   (clock),
      .i_rst   (Reset),
      .i_clear (w_tmr_clr),
      .i_limit (w_limit),
      .o_tc    (w_tc)
   );

   // Next-state, timer control and pending/overflow bookkeeping.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_clr   = 1'b1;
      w_limit     = CW'(HOLD_CYCLES - 1);
      w_accept    = 1'b0;
`ifdef VOTE_ACK_QUEUE_EN
      w_dec       = 1'b0;
      w_sat       = (r_pend == PW'(MAX_PENDING));
`endif
      case (r_state)
         ACK_IDLE: begin
            if (din) begin
               w_state_nxt = ACK_ON;
            end else begin
               w_state_nxt = ACK_IDLE;
            end
         end
         ACK_ON: begin
            w_tmr_clr = w_tc;
            w_accept  = din;
            if (w_tc) begin
               w_state_nxt = ACK_GAP;
            end else begin
               w_state_nxt = ACK_ON;
            end
         end
         ACK_GAP: begin
            w_limit   = CW'(GAP_CYCLES - 1);
            w_tmr_clr = w_tc;
            if (w_tc) begin
`ifdef VOTE_ACK_QUEUE_EN
               // A pulse on the last gap cycle starts the next burst directly instead of queuing.
               if (din || (r_pend != '0)) begin
                  w_state_nxt = ACK_ON;
                  w_dec       = ~din;
               end else begin
                  w_state_nxt = ACK_IDLE;
               end
`else
               w_state_nxt = ACK_IDLE;
               w_accept    = din;
`endif
            end else begin
               w_state_nxt = ACK_GAP;
               w_accept    = din;
            end
         end
         default: begin
            w_state_nxt = ACK_IDLE;
         end
      endcase
`ifdef VOTE_ACK_QUEUE_EN
      if (w_accept && !w_sat) begin
         w_pend_nxt = r_pend + PW'(1);
      end else if (w_dec) begin
         w_pend_nxt = r_pend - PW'(1);
      end else begin
         w_pend_nxt = r_pend;
      end
      w_ovf_nxt = r_ovf | (w_accept & w_sat);
`else
      w_ovf_nxt = r_ovf | w_accept;
`endif
   end

   // State and registered outputs; outputs reflect the state being entered.
   always_ff @(posedge clock) begin
      if (Reset) begin
         r_state <= ACK_IDLE;
         r_dout  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef VOTE_ACK_QUEUE_EN
         r_pend  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= (w_state_nxt == ACK_ON);
         r_busy  <= (w_state_nxt != ACK_IDLE);
         r_ovf   <= w_ovf_nxt;
`ifdef VOTE_ACK_QUEUE_EN
         r_pend  <= w_pend_nxt;
`endif
      end
   end

   assign dout     = r_dout;
   assign busy     = r_busy;
   assign overflow = r_ovf;
`ifdef VOTE_ACK_QUEUE_EN
   assign pending  = r_pend;
`else
   assign pending  = '0;
`endif

endmodule

// File: doc/vote_ack_stretcher.md
# vote_ack_stretcher

Converts single-cycle event pulses, such as those from the button debouncer, into fixed-length level outputs that can drive the vote-acknowledge LED or buzzer. Each accepted pulse produces one high burst of `HOLD_CYCLES` cycles, followed by a mandatory low gap of `GAP_CYCLES` cycles. Pulses that arrive while a burst or gap is in progress are counted and replayed in order, so a human sees or hears one distinct acknowledgement per vote.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50000000: cycles `dout` stays high per burst; must be ≥1.
- `GAP_CYCLES`, default 25000000: forced-low cycles after each burst; must be ≥1.
- `MAX_PENDING`, default 7: saturation limit of the pending-pulse counter; must be ≥1.

Ports (one clock; `Reset` is synchronous and active-high):
- `clock`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `din`  in  1  event pulse, nominally one cycle wide; sampled every cycle.
- `dout`  out  1  stretched acknowledge level.
- `busy`  out  1  high whenever the state is not IDLE.
- `pending`  out  `$clog2(MAX_PENDING+1)`  number of queued, unserved pulses.
- `overflow`  out  1  sticky flag: a pulse was lost; cleared only by `Reset`.

## Operation
- FSM states: IDLE, ON, GAP. All outputs are registered.
- **IDLE**
  - `din`=1 → ON; the hold counter is cleared.
  - `pending` is unchanged and stays 0.
- **ON**
  - `dout`=1.
  - The counter counts 0..HOLD_CYCLES-1.
  - At the terminal count the state moves to GAP and the counter is cleared.
- **GAP**
  - `dout`=0.
  - The counter counts 0..GAP_CYCLES-1.
  - At the terminal count, let `effective = pending + din`:
    - `effective` > 0 → ON, and `pending` becomes `effective - 1`.
    - `effective` = 0 → IDLE.
- **`din`=1 in ON or GAP, other than at the GAP terminal count:** `pending` increments.
- **Saturation:** if `pending` is already MAX_PENDING, it holds, the pulse is dropped, and `overflow` sets.
- **Held input:** if `din` stays high for several cycles, each cycle is counted as a separate pulse. Upstream is expected to send single-cycle pulses.
- **Counter width:** the counter is `$clog2(max(HOLD_CYCLES,GAP_CYCLES))` bits and never wraps. Terminal-count compares use parameter-minus-one.

## Timing
- Reset values: `dout`=0, `busy`=0, `pending`=0, `overflow`=0, state IDLE, counter 0.
- A `Reset` asserted in any cycle overrides every other input on the next edge, including mid-burst and mid-gap.
- Latency: `din` sampled high in IDLE at edge t → `dout`=1 from cycle t+1.
- One burst: `dout` is high for exactly HOLD_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
- `busy` covers both the burst and the gap: HOLD_CYCLES+GAP_CYCLES cycles.
- Back-to-back replay: the next burst's first high cycle follows the last gap cycle directly; no IDLE cycle is inserted.
- Minimum period between burst starts: HOLD_CYCLES+GAP_CYCLES.
- `pending` and `overflow` update on the same edge that samples `din`.

## Configuration
- Macro: `VOTE_ACK_QUEUE_EN`.
- **Defined:** pending-count queuing behaves as described above.
- **Undefined:**
  - `din` is ignored in ON and GAP, including the GAP terminal count.
  - Each ignored pulse sets `overflow`.
  - `pending` is tied to 0; no counter logic is synthesized.
  - The GAP terminal count always goes to IDLE.

## Structure
- Shared package `evm_pkg`:
  - the state enum typedef (`ACK_IDLE`, `ACK_ON`, `ACK_GAP`);
  - the width helper used for the counter and `pending` sizing.
- Sub-module `hold_timer`:
  - loadable up-counter with a terminal-count output, parameterized on width;
  - instantiated once, with the limit muxed between HOLD_CYCLES-1 and GAP_CYCLES-1 by state.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3. Scenarios 1–5 run with `VOTE_ACK_QUEUE_EN` defined.
1. Reset, then `din` pulse at cycle 10 → `dout`=1 in cycles 11–14, 0 in 15–16, `busy`=1 in 11–16, IDLE in cycle 17.
2. Pulse at 10, then pulses at 12, 13, 14 → `pending` reaches 3. Four bursts start at 11, 17, 23, 29. `pending` decrements at each replay and `overflow` stays 0.
3. Pulse at 10, then five pulses at 11–15 → `pending` saturates at 3 and `overflow`=1. `overflow` stays 1 after all bursts complete, until `Reset`.
4. `Reset` at cycle 13 during a burst with `pending`=2 → at cycle 14, `dout`=0, `busy`=0, `pending`=0, `overflow`=0, and no further bursts occur.
5. Single pulse at 10, second pulse at 16 (last GAP cycle, `pending`=0) → second burst starts at 17; `pending` never becomes nonzero.
6. `VOTE_ACK_QUEUE_EN` undefined; pulses at 10 and 12 → only one burst (cycles 11–14), `overflow`=1, `pending` constantly 0.
